my_32x32_regfile: RTL and testbench
===================================

MY_32X32_REGFILE -- requirements
Module: my_32x32_regfile

Interface
REQ-001 Parameters: none; register count fixed at 32, data width fixed at 32.
REQ-002 clock  in  1  sole clock; all state updates on rising edge.
REQ-003 ctrl_reset_n  in  1  synchronous, active-low reset, sampled on rising edge of clock.
REQ-004 ctrl_writeEnable  in  1  write strobe for current cycle.
REQ-005 ctrl_writeReg  in  5  write destination index.
REQ-006 data_writeReg  in  32  write data.
REQ-007 ctrl_readRegA  in  5  read port A index.
REQ-008 ctrl_readRegB  in  5  read port B index.
REQ-009 ctrl_markPending  in  1  decode-stage strobe: destination reg gets an in-flight producer.
REQ-010 ctrl_markReg  in  5  index to mark pending.
REQ-011 data_readRegA  out  32  port A read data.
REQ-012 data_readRegB  out  32  port B read data.
REQ-013 pending_readRegA  out  1  port A source has an outstanding producer (stall request).
REQ-014 pending_readRegB  out  1  port B source has an outstanding producer.

Function
REQ-015 Storage SHALL be 31 writable 32-bit registers r1..r31; r0 SHALL read 0 always, and writes to r0 SHALL be discarded.
REQ-016 Write SHALL commit at the rising edge when ctrl_writeEnable=1 and ctrl_writeReg!=0; other registers unchanged.
REQ-017 Reads SHALL be combinational (zero-cycle latency) from the indexed register.
REQ-018 Write-through bypass: if ctrl_writeEnable=1, ctrl_writeReg!=0 and ctrl_writeReg equals a read index in the same cycle, that port SHALL output data_writeReg.
REQ-019 Both ports MAY address the same register; both SHALL return identical data, including bypass.
REQ-020 Scoreboard: one pending bit per register; r0's bit SHALL be constant 0.
REQ-021 ctrl_markPending=1 with ctrl_markReg!=0 SHALL set that bit at the rising edge.
REQ-022 A committed write (per REQ-016) SHALL clear the pending bit of ctrl_writeReg at the rising edge.
REQ-023 Mark and write to the same register in one cycle: bit SHALL end set (the newer producer wins); data still written.
REQ-024 Marking an already-pending register SHALL leave it set (no counting; one producer in flight per register).
REQ-025 pending_readRegX SHALL equal the stored bit of ctrl_readRegX, forced to 0 when the same-cycle write bypass of REQ-018 applies to that port.
REQ-026 Same-cycle mark of a read index SHALL NOT affect pending_readRegX until after the edge.
REQ-027 Pending outputs SHALL be 0 whenever the read index is 0.

Reset
REQ-028 While ctrl_reset_n=0 at a rising edge, all registers SHALL clear to 0 and all pending bits to 0; writes and marks that cycle SHALL be ignored.
REQ-029 After reset: data_readRegA/B=0 and pending_readRegA/B=0 for all indices until a write or mark; no bypass applies while ctrl_reset_n=0.
REQ-030 Reset asserted mid-operation SHALL discard all stored data and pending state in one edge; no partial clear.

Structure
REQ-031 Shared constants (REG_COUNT=32, REG_IDX_W=5, DATA_W=32, REG_ZERO=0) SHALL live in the shared processor include/package, not inline.
REQ-032 One sub-module, my_32bit_register (32-bit DFF with enable and synchronous active-low clear), SHALL be instantiated 31 times; read selection reuses the team's existing 32-bit 32:1 mux, plus bypass logic at this level.

Verification
REQ-033 Reset, then read all 32 indices on both ports -> all data 0, all pending 0.
REQ-034 Write r5=0xDEADBEEF, next cycle read A=5, B=0 -> A=0xDEADBEEF, B=0; write r0=0x12345678 -> r0 reads 0.
REQ-035 Same cycle write r7=0xCAFEF00D and read A=7, B=7 -> both output 0xCAFEF00D before the edge; r7 holds it after.
REQ-036 Mark r9; next cycle read A=9 -> pending_readRegA=1; write r9=0x1 with read A=9 -> pending 0, data 0x1; after edge pending stays 0.
REQ-037 Same cycle mark r3 and write r3=0xAA -> after edge r3=0xAA, pending_readRegA(A=3)=1.
REQ-038 Populate r1..r31 and mark r10, then ctrl_reset_n=0 for one edge with concurrent write r4=0x55 -> all regs 0, all pending 0, r4=0.

Source files
------------

// File: rtl/my_32x32_regfile_pkg.sv
// my_32x32_regfile_pkg: shared register-file constants, types and the 32:1 read mux
package my_32x32_regfile_pkg;
   localparam int REG_COUNT = 32;
   localparam int REG_IDX_W = 5;
   localparam int DATA_W = 32;
   localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;
   typedef logic [DATA_W-1:0] data_t;
   typedef logic [REG_IDX_W-1:0] idx_t;
   typedef logic [REG_COUNT-1:0][DATA_W-1:0] bank_t;
   function automatic data_t mux32(input bank_t b, input idx_t s);
      return b[s];
   endfunction
endpackage

// File: rtl/my_32x32_regfile_if.sv
// my_32x32_regfile_if: write, read and scoreboard-mark signals of the register file
interface my_32x32_regfile_if;
   import my_32x32_regfile_pkg::*;
   logic  ctrl_writeEnable;
   idx_t  ctrl_writeReg;
   data_t data_writeReg;
   idx_t  ctrl_readRegA;
   idx_t  ctrl_readRegB;
   logic  ctrl_markPending;
   idx_t  ctrl_markReg;
   data_t data_readRegA;
   data_t data_readRegB;
   logic  pending_readRegA;
   logic  pending_readRegB;
   modport master (
      output ctrl_writeEnable, ctrl_writeReg, data_writeReg, ctrl_readRegA, ctrl_readRegB,
             ctrl_markPending, ctrl_markReg,
      input  data_readRegA, data_readRegB, pending_readRegA, pending_readRegB
   );
   modport slave (
      input  ctrl_writeEnable, ctrl_writeReg, data_writeReg, ctrl_readRegA, ctrl_readRegB,
             ctrl_markPending, ctrl_markReg,
      output data_readRegA, data_readRegB, pending_readRegA, pending_readRegB
   );
endinterface

// File: rtl/my_32x32_regfile_reg.sv
// my_32bit_register: 32-bit register with load enable and synchronous active-low clear
module my_32bit_register
   import my_32x32_regfile_pkg::*;
(
   input  logic  clock,
   input  logic  i_clr_n,
   input  logic  i_en,
   input  data_t i_d,
   output data_t o_q
);
   data_t r_q;
   always_ff @(posedge clock) r_q <= !i_clr_n ? '0 : i_en ? i_d : r_q;
   assign o_q = r_q;
endmodule

// File: rtl/my_32x32_regfile.sv
// my_32x32_regfile: 2-read/1-write register file with write-through bypass and pending scoreboard
module my_32x32_regfile
   import my_32x32_regfile_pkg::*;
(
   input logic clock,
   input logic ctrl_reset_n,
   my_32x32_regfile_if.slave bus
);
   bank_t w_q;
   logic [REG_COUNT-1:0] r_pend;
   logic [REG_COUNT-1:0] w_pend_nxt;
   logic w_commit;
   logic w_mark;
   logic w_byp_a;
   logic w_byp_b;
   // writes and bypass are suppressed while reset is asserted
   assign w_commit = ctrl_reset_n && bus.ctrl_writeEnable && bus.ctrl_writeReg != REG_ZERO;
   assign w_mark = bus.ctrl_markPending && bus.ctrl_markReg != REG_ZERO;
   assign w_q[0] = '0;
   for (genvar i = 1; i < REG_COUNT; i++) begin : g_reg
      my_32bit_register u_reg (
         .clock   (clock),
         .i_clr_n (ctrl_reset_n),
         .i_en    (w_commit && bus.ctrl_writeReg == idx_t'(i)),
         .i_d     (bus.data_writeReg),
         .o_q     (w_q[i])
      );
   end
   // mark is applied after the write clear so a same-cycle new producer wins
   always_comb begin
      w_pend_nxt = r_pend;
      if (w_commit) w_pend_nxt[bus.ctrl_writeReg] = 1'b0;
      if (w_mark) w_pend_nxt[bus.ctrl_markReg] = 1'b1;
      w_pend_nxt[REG_ZERO] = 1'b0;
   end
   always_ff @(posedge clock) r_pend <= ctrl_reset_n ? w_pend_nxt : '0;
   assign w_byp_a = w_commit && bus.ctrl_writeReg == bus.ctrl_readRegA;
   assign w_byp_b = w_commit && bus.ctrl_writeReg == bus.ctrl_readRegB;
   assign bus.data_readRegA = w_byp_a ? bus.data_writeReg : mux32(w_q, bus.ctrl_readRegA);
   assign bus.data_readRegB = w_byp_b ? bus.data_writeReg : mux32(w_q, bus.ctrl_readRegB);
   assign bus.pending_readRegA = !w_byp_a && r_pend[bus.ctrl_readRegA];
   assign bus.pending_readRegB = !w_byp_b && r_pend[bus.ctrl_readRegB];
endmodule

// File: tb/tb_my_32x32_regfile.sv
// tb_my_32x32_regfile: directed and randomized checks against a behavioural register-file model
module tb_my_32x32_regfile;
   logic clock;
   logic ctrl_reset_n;
   logic chk_en;
   int checks;
   int failures;
   logic [31:0] m_mem [32];
   logic m_pend [32];
   my_32x32_regfile_if bus ();
   my_32x32_regfile dut (
      .clock        (clock),
      .ctrl_reset_n (ctrl_reset_n),
      .bus          (bus)
   );
   initial clock = 1'b0;
   always #5 clock = ~clock;
   task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clock);
      #1;
   endtask
   task automatic settle();
      @(negedge clock);
      #1;
   endtask
   task automatic idle();
      bus.ctrl_writeEnable = 1'b0;
      bus.ctrl_markPending = 1'b0;
   endtask
   function automatic logic [4:0] pick();
      return ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
   endfunction
   // model state follows the architectural rules: reset clears, a write stores and retires, a mark sets
   always @(posedge clock) begin
      if (!ctrl_reset_n) begin
         for (int k = 0; k < 32; k++) begin
            m_mem[k] <= '0;
            m_pend[k] <= 1'b0;
         end
      end else begin
         if (bus.ctrl_writeEnable && bus.ctrl_writeReg != 0) begin
            m_mem[bus.ctrl_writeReg] <= bus.data_writeReg;
            m_pend[bus.ctrl_writeReg] <= 1'b0;
         end
         if (bus.ctrl_markPending && bus.ctrl_markReg != 0) m_pend[bus.ctrl_markReg] <= 1'b1;
      end
   end
   always @(negedge clock) begin : cmp
      logic ba, bb;
      if (chk_en) begin
         ba = ctrl_reset_n && bus.ctrl_writeEnable && bus.ctrl_writeReg != 0 && bus.ctrl_writeReg == bus.ctrl_readRegA;
         bb = ctrl_reset_n && bus.ctrl_writeEnable && bus.ctrl_writeReg != 0 && bus.ctrl_writeReg == bus.ctrl_readRegB;
         lit("data_readRegA", bus.data_readRegA, ba ? bus.data_writeReg : (bus.ctrl_readRegA == 0 ? 32'h0 : m_mem[bus.ctrl_readRegA]));
         lit("data_readRegB", bus.data_readRegB, bb ? bus.data_writeReg : (bus.ctrl_readRegB == 0 ? 32'h0 : m_mem[bus.ctrl_readRegB]));
         lit("pending_readRegA", 32'(bus.pending_readRegA), 32'(!ba && bus.ctrl_readRegA != 0 && m_pend[bus.ctrl_readRegA]));
         lit("pending_readRegB", 32'(bus.pending_readRegB), 32'(!bb && bus.ctrl_readRegB != 0 && m_pend[bus.ctrl_readRegB]));
      end
   end
   initial begin
      checks = 0;
      failures = 0;
      chk_en = 1'b0;
      ctrl_reset_n = 1'b0;
      idle();
      bus.ctrl_writeReg = '0;
      bus.data_writeReg = '0;
      bus.ctrl_readRegA = '0;
      bus.ctrl_readRegB = '0;
      bus.ctrl_markReg = '0;
      step();
      step();
      ctrl_reset_n = 1'b1;
      chk_en = 1'b1;
      for (int i = 0; i < 32; i++) begin
         bus.ctrl_readRegA = 5'(i);
         bus.ctrl_readRegB = 5'(31 - i);
         settle();
         lit("rst_dataA", bus.data_readRegA, 32'h0);
         lit("rst_dataB", bus.data_readRegB, 32'h0);
         lit("rst_pendA", 32'(bus.pending_readRegA), 32'h0);
         lit("rst_pendB", 32'(bus.pending_readRegB), 32'h0);
         step();
      end
      bus.ctrl_writeEnable = 1'b1;
      bus.ctrl_writeReg = 5'd5;
      bus.data_writeReg = 32'hDEADBEEF;
      step();
      idle();
      bus.ctrl_readRegA = 5'd5;
      bus.ctrl_readRegB = 5'd0;
      settle();
      lit("r5_dataA", bus.data_readRegA, 32'hDEADBEEF);
      lit("r0_dataB", bus.data_readRegB, 32'h0);
      step();
      bus.ctrl_writeEnable = 1'b1;
      bus.ctrl_writeReg = 5'd0;
      bus.data_writeReg = 32'h12345678;
      bus.ctrl_readRegA = 5'd0;
      settle();
      lit("r0_wr_same_cycle", bus.data_readRegA, 32'h0);
      step();
      idle();
      settle();
      lit("r0_after_wr", bus.data_readRegA, 32'h0);
      step();
      bus.ctrl_writeEnable = 1'b1;
      bus.ctrl_writeReg = 5'd7;
      bus.data_writeReg = 32'hCAFEF00D;
      bus.ctrl_readRegA = 5'd7;
      bus.ctrl_readRegB = 5'd7;
      settle();
      lit("byp_r7_A", bus.data_readRegA, 32'hCAFEF00D);
      lit("byp_r7_B", bus.data_readRegB, 32'hCAFEF00D);
      step();
      idle();
      settle();
      lit("r7_held", bus.data_readRegA, 32'hCAFEF00D);
      step();
      bus.ctrl_markPending = 1'b1;
      bus.ctrl_markReg = 5'd9;
      bus.ctrl_readRegA = 5'd9;
      settle();
      lit("mark_same_cycle", 32'(bus.pending_readRegA), 32'h0);
      step();
      idle();
      settle();
      lit("r9_pending", 32'(bus.pending_readRegA), 32'h1);
      step();
      bus.ctrl_writeEnable = 1'b1;
      bus.ctrl_writeReg = 5'd9;
      bus.data_writeReg = 32'h1;
      settle();
      lit("r9_byp_pend", 32'(bus.pending_readRegA), 32'h0);
      lit("r9_byp_data", bus.data_readRegA, 32'h1);
      step();
      idle();
      settle();
      lit("r9_pend_after", 32'(bus.pending_readRegA), 32'h0);
      step();
      bus.ctrl_markPending = 1'b1;
      bus.ctrl_markReg = 5'd3;
      bus.ctrl_writeEnable = 1'b1;
      bus.ctrl_writeReg = 5'd3;
      bus.data_writeReg = 32'hAA;
      step();
      idle();
      bus.ctrl_readRegA = 5'd3;
      settle();
      lit("r3_data", bus.data_readRegA, 32'hAA);
      lit("r3_pend", 32'(bus.pending_readRegA), 32'h1);
      step();
      for (int i = 1; i < 32; i++) begin
         bus.ctrl_writeEnable = 1'b1;
         bus.ctrl_writeReg = 5'(i);
         bus.data_writeReg = 32'(i) * 32'h01010101;
         step();
      end
      idle();
      bus.ctrl_markPending = 1'b1;
      bus.ctrl_markReg = 5'd10;
      step();
      idle();
      bus.ctrl_readRegA = 5'd10;
      bus.ctrl_readRegB = 5'd20;
      settle();
      lit("pop_r10_pend", 32'(bus.pending_readRegA), 32'h1);
      lit("pop_r20_data", bus.data_readRegB, 32'h14141414);
      step();
      ctrl_reset_n = 1'b0;
      bus.ctrl_writeEnable = 1'b1;
      bus.ctrl_writeReg = 5'd4;
      bus.data_writeReg = 32'h55;
      bus.ctrl_readRegA = 5'd4;
      settle();
      lit("no_byp_in_rst", bus.data_readRegA, 32'h04040404);
      step();
      ctrl_reset_n = 1'b1;
      idle();
      for (int i = 0; i < 32; i++) begin
         bus.ctrl_readRegA = 5'(i);
         bus.ctrl_readRegB = 5'(i);
         settle();
         lit("mid_rst_dataA", bus.data_readRegA, 32'h0);
         lit("mid_rst_dataB", bus.data_readRegB, 32'h0);
         lit("mid_rst_pendA", 32'(bus.pending_readRegA), 32'h0);
         lit("mid_rst_pendB", 32'(bus.pending_readRegB), 32'h0);
         step();
      end
      for (int n = 0; n < 3000; n++) begin
         ctrl_reset_n = ($urandom_range(0, 99) != 0);
         bus.ctrl_writeEnable = 1'($urandom_range(0, 1));
         bus.ctrl_writeReg = pick();
         bus.data_writeReg = $urandom;
         bus.ctrl_readRegA = pick();
         bus.ctrl_readRegB = ($urandom_range(0, 3) == 0) ? bus.ctrl_readRegA : pick();
         bus.ctrl_markPending = ($urandom_range(0, 2) == 0);
         bus.ctrl_markReg = pick();
         step();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
